// File: rtl/opr_phase_sequencer.sv
// rtl/opr_phase_sequencer.sv - per-phase ck/stb timing sequencer for the instruction decoders
// Moore FSM: every output decodes from the state, phase counter and fault registers.
module opr_phase_sequencer #(
  parameter int NPHASE = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic              done,
  output logic [NPHASE-1:0] ck,
  output logic [NPHASE-1:0] stb,
  output logic              instr_start,
  output logic              busy,
  output logic              fault,
  output logic [3:0]        phase
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PA,
    S_PB,
    S_GAP
  } state_t;

  localparam logic [3:0] LAST_PHASE = 4'(NPHASE);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic       fault_q;
  logic       fault_nx;
  logic       in_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      fault_q <= fault_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fault_nx = fault_q;
    case (state)
      S_IDLE: begin
        cnt_nx = 4'd0;
        if (run || step) begin
          state_nx = S_START;
        end
      end
      S_START: begin
        fault_nx = 1'b0;
        cnt_nx   = 4'd1;
        state_nx = S_PA;
      end
      S_PA: begin
        // done ends the instruction before this phase's write strobe fires
        if (done) begin
          state_nx = S_GAP;
        end else begin
          state_nx = S_PB;
        end
      end
      S_PB: begin
        if (cnt == LAST_PHASE) begin
          fault_nx = 1'b1;
          cnt_nx   = 4'd0;
          state_nx = S_IDLE;
        end else begin
          cnt_nx   = cnt + 4'd1;
          state_nx = S_PA;
        end
      end
      S_GAP: begin
        cnt_nx = 4'd0;
        if (run) begin
          state_nx = S_START;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        cnt_nx   = 4'd0;
        state_nx = S_IDLE;
      end
    endcase
  end

  assign in_phase = (state == S_PA) || (state == S_PB);

  // ck stays high through PB so operand data is stable while stb fires
  always_comb begin
    ck  = '0;
    stb = '0;
    for (int i = 0; i < NPHASE; i++) begin
      if (in_phase && (cnt == 4'(i + 1))) begin
        ck[i]  = 1'b1;
        stb[i] = (state == S_PB);
      end
    end
  end

  assign instr_start = (state == S_START);
  assign busy        = (state != S_IDLE);
  assign fault       = fault_q;
  assign phase       = in_phase ? cnt : 4'd0;

endmodule

// File: tb/tb_opr_phase_sequencer.sv
// tb/tb_opr_phase_sequencer.sv - scoreboard bench for opr_phase_sequencer
// Reference model tracks a linear position within the instruction rather than FSM states.
module tb_opr_phase_sequencer;

  localparam int N = 6;

  logic         clk;
  logic         reset;
  logic         run;
  logic         step;
  logic         done;
  logic [N-1:0] ck;
  logic [N-1:0] stb;
  logic         instr_start;
  logic         busy;
  logic         fault;
  logic [3:0]   phase;

  opr_phase_sequencer #(.NPHASE(N)) dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .step(step),
    .done(done),
    .ck(ck),
    .stb(stb),
    .instr_start(instr_start),
    .busy(busy),
    .fault(fault),
    .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] ck;
    logic [N-1:0] stb;
    logic         is;
    logic         busy;
    logic         fault;
    logic [3:0]   phase;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // pos: -1 idle, -2 gap, 0 start, 1..2N phase cycles (odd = ck only, even = ck+stb)
  int   pos = -1;
  logic mfault = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    int   ph;
    ph       = (pos + 1) / 2;
    e.ck     = '0;
    e.stb    = '0;
    if (pos >= 1) begin
      e.ck = N'(1) << (ph - 1);
      if (pos % 2 == 0) e.stb = e.ck;
    end
    e.is     = (pos == 0);
    e.busy   = (pos != -1);
    e.fault  = mfault;
    e.phase  = (pos >= 1) ? 4'(ph) : 4'd0;
    return e;
  endfunction

  // kdone > 0: return done during the ck-only cycle of that phase; otherwise drive dr
  task automatic cycle(input logic r, input logic s, input int kdone, input logic dr);
    logic d;
    @(posedge clk);
    #1;
    q.push_back(expect_now());
    if (kdone > 0) d = (pos >= 1) && (pos % 2 == 1) && ((pos + 1) / 2 == kdone);
    else           d = dr;
    run  = r;
    step = s;
    done = d;
    if (pos == -1) begin
      if (r || s) pos = 0;
    end else if (pos == -2) begin
      pos = r ? 0 : -1;
    end else if (pos == 0) begin
      mfault = 1'b0;
      pos    = 1;
    end else if (pos % 2 == 1) begin
      pos = d ? -2 : pos + 1;
    end else if (pos == 2 * N) begin
      mfault = 1'b1;
      pos    = -1;
    end else begin
      pos = pos + 1;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ck", int'(ck), int'(e.ck));
      chk("stb", int'(stb), int'(e.stb));
      chk("instr_start", int'(instr_start), int'(e.is));
      chk("busy", int'(busy), int'(e.busy));
      chk("fault", int'(fault), int'(e.fault));
      chk("phase", int'(phase), int'(e.phase));
    end
  end

  initial begin
    int guard;
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ck", int'(ck), 0);
    chk("reset_stb", int'(stb), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_fault", int'(fault), 0);
    chk("reset_phase", int'(phase), 0);
    chk("reset_instr_start", int'(instr_start), 0);
    reset = 1'b0;

    // step, done on ck2
    cycle(0, 1, 2, 0);
    repeat (7) cycle(0, 0, 2, 0);
    // step, done on ck4
    cycle(0, 1, 4, 0);
    repeat (11) cycle(0, 0, 4, 0);
    // run held, done on ck3 back to back
    repeat (22) cycle(1, 0, 3, 0);
    repeat (6) cycle(0, 0, 3, 0);
    // done never arrives: fault, then the next step clears it
    cycle(0, 1, 0, 0);
    repeat (16) cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 0);
    repeat (5) cycle(0, 0, 1, 0);
    // step pulses while busy are ignored
    cycle(0, 1, 3, 0);
    cycle(0, 0, 3, 0);
    cycle(0, 1, 3, 0);
    cycle(0, 0, 3, 0);
    cycle(0, 1, 3, 0);
    repeat (8) cycle(0, 0, 3, 0);
    // done while in the strobe cycle is ignored
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (6) cycle(0, 0, 2, 0);

    // async reset during PB(2)
    cycle(0, 1, 0, 0);
    guard = 0;
    while (pos != 4 && guard < 10) begin
      cycle(0, 0, 0, 0);
      guard++;
    end
    chk("reach_pb2", pos, 4);
    @(posedge clk);
    #1;
    chk("pb2_ck", int'(ck), 2);
    chk("pb2_stb", int'(stb), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_ck", int'(ck), 0);
    chk("async_stb", int'(stb), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_phase", int'(phase), 0);
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    run    = 1'b0;
    step   = 1'b0;
    done   = 1'b0;
    pos    = -1;
    mfault = 1'b0;
    repeat (4) cycle(0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic r;
      logic s;
      logic d;
      r = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 5) == 0);
      cycle(r, s, 0, d);
    end
    repeat (20) cycle(0, 0, 1, 0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opr_phase_sequencer.md
Name: opr_phase_sequencer

Overview:
- Timing sequencer for the instruction-execution datapath. It generates the per-phase level strobes ckN and the write strobes stbN that the instruction decoders (OPR group 1/2/3 and peers) AND with their decode terms.
- It starts instructions on run/step, ends each instruction when the OR-ed decoder `done` returns, and flags a fault if `done` never arrives.
- It sits between the front-panel run control and all INSTx decoders.

Parameters:
- NPHASE, 6, number of execution phases (ck1..ckNPHASE); legal range 2..8.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- run  input  1  level; continuous execution while high
- step  input  1  one-cycle pulse; execute exactly one instruction from idle
- done  input  1  OR of all decoder done terms (combinational from ckN)
- ck  output  NPHASE  ck[i-1] = phase i level strobe, one-hot or zero
- stb  output  NPHASE  stb[i-1] = phase i write strobe, one-hot or zero
- instr_start  output  1  one-cycle pulse preceding phase 1 (IR/operand latch)
- busy  output  1  high from instr_start through the gap cycle
- fault  output  1  sticky; no done by end of last phase
- phase  output  4  current phase number 1..NPHASE, 0 when not in a phase

Behaviour:
- Async reset: state IDLE; ck=0, stb=0, instr_start=0, busy=0, fault=0, phase=0. Reset mid-instruction aborts immediately, with no further strobes.
- All outputs are registered or decoded from registered state only (Moore). No input reaches an output combinationally.
- States: IDLE, START, PA(n), PB(n), GAP. n is held in a 4-bit phase counter.
- IDLE: outputs low.
  - run=1 or step=1 → START.
  - Both high → START (single entry).
- START: instr_start=1, busy=1 → PA(1). Clears fault.
- PA(n): ck[n-1]=1, stb=0, phase=n, busy=1.
  - Sample done at the end of the cycle.
  - done=1 → GAP, and stb[n-1] is NOT issued.
  - done=0 → PB(n).
- PB(n): ck[n-1]=1, stb[n-1]=1 (ck held so data stays on the bus while the strobe fires), phase=n.
  - done ignored in PB.
  - n<NPHASE → PA(n+1).
  - n=NPHASE → fault←1, → IDLE (run ignored; fault halts).
- GAP: all ck/stb low, busy=1, phase=0.
  - run=1 → START.
  - Otherwise → IDLE.
- Latency: instruction ending with done on ckK takes 2K+1 cycles from START to GAP inclusive, i.e. START, then 2(K-1) cycles for phases 1..K-1, then PA(K), then GAP.
- Phase counter never wraps: PB(NPHASE) always exits to IDLE.
- step while busy is ignored, not queued.
- run deasserted mid-instruction: the instruction completes, then IDLE after GAP.
- run asserted with fault=1: START clears fault and proceeds.
- At most one ck bit and one stb bit is high in any cycle; stb[i] implies ck[i].

Test Plan:
- Step, done returned on ck2 (OPR1 profile) → cycle1 START/instr_start; cycles 2–3 ck=000001, stb=000001 in cycle 3 only; cycle 4 ck=000010, stb=0; cycle 5 GAP; cycle 6 IDLE, busy=0. Total 5 busy cycles.
- Step, done on ck4 (SWP profile) → stb pulses on phases 1,2,3 only; ck4 high one cycle; busy for 9 cycles; no stb4.
- run held high, done on ck3 repeatedly → instr_start every 7 cycles (START, 4 phase cycles, PA(3), GAP); no IDLE cycle between instructions.
- Step, done never asserted (NPHASE=6) → ck1..ck6 each two cycles, stb1..stb6 each once; fault=1 after PB(6); state IDLE; next step clears fault at START.
- Reset asserted during PB(2) → ck, stb, busy, phase zero in the same cycle (async); after release with run=0, outputs stay 0.
- step pulses at cycles 2 and 4 of a running instruction, with run=0 → exactly one instr_start; returns to IDLE after the first instruction.
